hs_src_ctrl: RTL
================

Name: hs_src_ctrl

Overview:
- Source-side controller for a toggle req/ack handshake that carries a DW-bit word to another clock domain.
- Accepts words from a local producer over valid/ready and holds each word stable on data_o.
- Signals each new word by toggling req_o.
- Waits for the destination's ack toggle, which arrives asynchronously and is resynchronized through a DP-stage flop chain; then frees the producer for the next word.

Parameters:
- DW, 32, payload width in bits
- DP, 2, synchronizer depth for ack_i; legal values 2..4
- CW, 16, width of the completed-transfer counter
- TO_CYC, 1024, WAIT_ACK timeout in clk_i cycles (only used with HS_SRC_TIMEOUT_EN)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous reset, active-low
- in_valid_i  in  1  producer has a word
- in_ready_o  out  1  controller accepts a word this cycle
- in_data_i  in  DW  producer word
- data_o  out  DW  held word toward the destination domain
- req_o  out  1  request toggle; driven directly from a flop
- ack_i  in  1  destination ack toggle; asynchronous to clk_i
- busy_o  out  1  transfer outstanding (state != IDLE)
- xfer_cnt_o  out  CW  completed-transfer count
- proto_err_o  out  1  sticky protocol-error flag
- clr_i  in  1  clears proto_err_o; also clears timeout_o when the option is built
- timeout_o  out  1  sticky timeout flag; present only with HS_SRC_TIMEOUT_EN

Behaviour:
- One clock domain; every flop, including the synchronizer chain, uses the synchronous active-low rst_ni.
- Reset values: req_o=0, data_o=0, xfer_cnt_o=0, proto_err_o=0, busy_o=0, timeout_o=0, all sync stages=0, state=IDLE.
- ack_s is ack_i after DP flops. Latency from an ack_i edge to ack_s is DP cycles.
- in_ready_o = (state==IDLE) && !proto_err_o. It is combinational from flops only.
- IDLE:
  - On in_valid_i && in_ready_o: data_o <= in_data_i; req_o <= ~req_o; state <= WAIT_ACK.
  - req_o and data_o update on the same edge, so data_o is stable for at least one cycle before the destination can sample the new req_o level.
- WAIT_ACK:
  - in_ready_o=0; data_o and req_o are held.
  - When ack_s == req_o: state <= IDLE and xfer_cnt_o increments.
  - xfer_cnt_o wraps from 2^CW-1 to 0.
  - in_ready_o returns to 1 the cycle after the match. Minimum accept-to-accept spacing is 2 + DP cycles plus the destination round trip.
- Protocol error: ack_s != req_o while in IDLE (a spurious ack toggle).
  - Sets proto_err_o and blocks acceptance until clr_i.
  - clr_i only clears the flag; it does not change req_o.
  - If the mismatch persists after clr_i, the flag is set again on the next cycle.
- Simultaneous events:
  - clr_i in the same cycle as a new error: the error wins and the flag stays 1.
  - Accept and completion cannot coincide, because they occur in different states.
- Reset mid-transfer: the word is abandoned and req_o returns to 0. The destination domain must be reset together; this is a system requirement.
- in_valid_i may drop without acceptance; there is no stickiness requirement on the producer.

Optional Feature:
- Macro: HS_SRC_TIMEOUT_EN.
- With the macro defined:
  - A down-counter loads TO_CYC-1 on entry to WAIT_ACK and decrements each WAIT_ACK cycle.
  - On reaching 0 without a match: timeout_o <= 1 (sticky) and state <= IDLE; req_o and xfer_cnt_o are not changed.
  - The next ack_s mismatch then raises proto_err_o.
  - clr_i clears timeout_o.
- Without the macro: no counter and no timeout_o port; WAIT_ACK waits indefinitely.

Decomposition:
- Shared package hs_pkg holds:
  - the state typedef: enum logic [1:0] {HS_IDLE, HS_WAIT_ACK}
  - localparam HS_DP_MIN = 2
- Natural sub-module: hs_ack_sync, a DP-stage synchronous-reset flop chain, width 1.
  - It matches gen_ticks_sync except for the reset style.
  - It is kept separate so that timing constraints can target its first stage.

Test Plan:
- Reset, then idle → in_ready_o=1, req_o=0, data_o=0, xfer_cnt_o=0, busy_o=0.
- Accept 0xDEADBEEF; loopback ack_i=req_o after 3 cycles, DP=2:
  - req_o=1 one cycle after accept; data_o=0xDEADBEEF;
  - in_ready_o returns to 1 exactly 3+DP+1 cycles after the ack edge relation holds;
  - xfer_cnt_o=1.
- Back-to-back: 5 words 0x1..0x5 with in_valid_i held high → five req_o toggles; each data_o value is stable across its whole WAIT_ACK; xfer_cnt_o=5.
- Spurious ack: toggle ack_i while in IDLE → proto_err_o=1 after DP+1 cycles, in_ready_o=0. Restore ack_i and pulse clr_i → flag clears and acceptance resumes.
- Wrap: CW=4, 17 transfers → xfer_cnt_o=1.
- With HS_SRC_TIMEOUT_EN, TO_CYC=8, ack never returns → timeout_o=1 exactly 8 cycles after entering WAIT_ACK, busy_o=0. Pulse clr_i → timeout_o=0.

Source files
------------

// File: rtl/hs_pkg.sv
// Shared types for the toggle req/ack handshake blocks.
package hs_pkg;

  typedef enum logic [1:0] {
    HS_IDLE,
    HS_WAIT_ACK
  } hs_state_e;

  localparam int HS_DP_MIN = 2;

endpackage

// File: rtl/hs_ack_sync.sv
// DP-stage single-bit resynchronizer for the asynchronous ack toggle.
// Kept as its own module so timing constraints can target stage 0.
module hs_ack_sync
  import hs_pkg::*;
#(
  parameter int DP = HS_DP_MIN
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d,
  output logic q
);

  logic stage_reg [DP];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stage_reg[0] <= 1'b0;
    end else begin
      stage_reg[0] <= d;
    end
  end

  for (genvar gi = 1; gi < DP; gi++) begin : g_stage
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        stage_reg[gi] <= 1'b0;
      end else begin
        stage_reg[gi] <= stage_reg[gi-1];
      end
    end
  end

  assign q = stage_reg[DP-1];

endmodule

// File: rtl/hs_src_ctrl.sv
// Source side of a toggle req/ack handshake: holds one word on data_o and
// toggles req_o per word. Build with HS_SRC_TIMEOUT_EN for the WAIT_ACK timeout.
module hs_src_ctrl
  import hs_pkg::*;
#(
  parameter int DW     = 32,
  parameter int DP     = 2,
  parameter int CW     = 16,
  parameter int TO_CYC = 1024
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [DW-1:0] in_data_i,
  output logic [DW-1:0] data_o,
  output logic          req_o,
  input  logic          ack_i,
  output logic          busy_o,
  output logic [CW-1:0] xfer_cnt_o,
  output logic          proto_err_o,
`ifdef HS_SRC_TIMEOUT_EN
  output logic          timeout_o,
`endif
  input  logic          clr_i
);

  hs_state_e     state_reg, state_next;
  logic          req_reg, req_next;
  logic [DW-1:0] data_reg, data_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          err_reg, err_next;
  logic          ack_s;
  logic          accept;
  logic          err_set;
  logic          ack_match;
  logic          to_hit;

  hs_ack_sync #(
    .DP (DP)
  ) u_ack_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d      (ack_i),
    .q      (ack_s)
  );

  assign in_ready_o = (state_reg == HS_IDLE) && !err_reg;
  assign accept     = in_valid_i && in_ready_o;
  assign ack_match  = (ack_s == req_reg);

`ifdef HS_SRC_TIMEOUT_EN
  localparam int TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic          to_reg, to_next;

  assign to_hit = (state_reg == HS_WAIT_ACK) && !ack_match && (to_cnt_reg == '0);

  // Down-counter is only meaningful in WAIT_ACK; it reloads on every accept.
  always_comb begin
    to_cnt_next = to_cnt_reg;
    if (accept) begin
      to_cnt_next = TW'(TO_CYC - 1);
    end else if (state_reg == HS_WAIT_ACK && !ack_match && to_cnt_reg != '0) begin
      to_cnt_next = to_cnt_reg - 1'b1;
    end
    to_next = to_hit ? 1'b1 : (clr_i ? 1'b0 : to_reg);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      to_cnt_reg <= '0;
      to_reg     <= 1'b0;
    end else begin
      to_cnt_reg <= to_cnt_next;
      to_reg     <= to_next;
    end
  end

  assign timeout_o = to_reg;
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    req_next   = req_reg;
    data_next  = data_reg;
    cnt_next   = cnt_reg;
    err_set    = 1'b0;
    case (state_reg)
      HS_IDLE: begin
        // Any ack movement while nothing is outstanding is a spurious toggle.
        err_set = !ack_match;
        if (accept) begin
          data_next  = in_data_i;
          req_next   = ~req_reg;
          state_next = HS_WAIT_ACK;
        end
      end
      HS_WAIT_ACK: begin
        if (ack_match) begin
          state_next = HS_IDLE;
          cnt_next   = cnt_reg + 1'b1;
        end else if (to_hit) begin
          state_next = HS_IDLE;
        end
      end
      default: state_next = HS_IDLE;
    endcase
    // A new error outranks a simultaneous clear.
    err_next = err_set ? 1'b1 : (clr_i ? 1'b0 : err_reg);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= HS_IDLE;
      req_reg   <= 1'b0;
      data_reg  <= '0;
      cnt_reg   <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      req_reg   <= req_next;
      data_reg  <= data_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  assign req_o       = req_reg;
  assign data_o      = data_reg;
  assign busy_o      = (state_reg != HS_IDLE);
  assign xfer_cnt_o  = cnt_reg;
  assign proto_err_o = err_reg;

endmodule
